// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-cycle controller.
// Optional quick-start behaviour is selected with MICROWAVE_QUICK_START_EN.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTING = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE        = 4'd9;
  localparam bcd_t SECS_WRAP_TENS  = 4'd5;
  localparam bcd_t QUICK_SECS_TENS = 4'd3;

  // Keypad codes 10..15 are not digits and must never enter the time.
  function automatic logic is_digit(input bcd_t d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/microwave_ctrl_bcd_countdown.sv
// Combinational one-second decrement of an MM:SS BCD time.
// A zero input is passed through unchanged so minutes can never underflow.
import microwave_pkg::*;

module bcd_countdown (
  input  logic [3:0] mins_tens,
  input  logic [3:0] mins_ones,
  input  logic [3:0] secs_tens,
  input  logic [3:0] secs_ones,
  output logic [3:0] dec_mins_tens,
  output logic [3:0] dec_mins_ones,
  output logic [3:0] dec_secs_tens,
  output logic [3:0] dec_secs_ones,
  output logic       is_zero
);

  assign is_zero = (mins_tens == 4'd0) && (mins_ones == 4'd0) &&
                   (secs_tens == 4'd0) && (secs_ones == 4'd0);

  // Borrow chain: seconds ones -> seconds tens -> minutes (secs wrap to 59).
  always_comb begin
    dec_mins_tens = mins_tens;
    dec_mins_ones = mins_ones;
    dec_secs_tens = secs_tens;
    dec_secs_ones = secs_ones;
    if (!is_zero) begin
      if (secs_ones != 4'd0) begin
        dec_secs_ones = secs_ones - 4'd1;
      end else if (secs_tens != 4'd0) begin
        dec_secs_ones = BCD_NINE;
        dec_secs_tens = secs_tens - 4'd1;
      end else begin
        dec_secs_ones = BCD_NINE;
        dec_secs_tens = SECS_WRAP_TENS;
        if (mins_ones != 4'd0) begin
          dec_mins_ones = mins_ones - 4'd1;
        end else begin
          dec_mins_ones = BCD_NINE;
          dec_mins_tens = mins_tens - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cook-cycle controller: keypad time entry, 1 Hz countdown,
// magnetron enable and done alarm. Define MICROWAVE_QUICK_START_EN to make
// start in IDLE with 00:00 load 00:30 and begin cooking.
// Within a state, the highest-priority strobe present claims the cycle even
// if it has no effect (e.g. an ignored start still swallows a key strobe).
import microwave_pkg::*;

module microwave_ctrl #(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] mins_tens,
  output logic [3:0] mins_ones,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [3:0] LAST_TICK = 4'(DONE_TICKS - 1);

  state_t     state_reg;
  bcd_t       mt_reg, mo_reg, st_reg, so_reg;
  logic       mag_on_reg, done_reg;
  logic [3:0] alarm_cnt_reg;

  bcd_t dec_mt, dec_mo, dec_st, dec_so;
  logic time_zero;
  logic dec_zero;

  bcd_countdown u_countdown (
    .mins_tens     (mt_reg),
    .mins_ones     (mo_reg),
    .secs_tens     (st_reg),
    .secs_ones     (so_reg),
    .dec_mins_tens (dec_mt),
    .dec_mins_ones (dec_mo),
    .dec_secs_tens (dec_st),
    .dec_secs_ones (dec_so),
    .is_zero       (time_zero)
  );

  assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                    (dec_st == 4'd0) && (dec_so == 4'd0);

  // Single-process FSM with registered time, magnetron and alarm outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_reg     <= IDLE;
      mt_reg        <= 4'd0;
      mo_reg        <= 4'd0;
      st_reg        <= 4'd0;
      so_reg        <= 4'd0;
      mag_on_reg    <= 1'b0;
      done_reg      <= 1'b0;
      alarm_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE, SETTING: begin
          if (stop) begin
            mt_reg    <= 4'd0;
            mo_reg    <= 4'd0;
            st_reg    <= 4'd0;
            so_reg    <= 4'd0;
            state_reg <= IDLE;
          end else if (start) begin
            if (!time_zero && door_closed) begin
              state_reg  <= COOKING;
              mag_on_reg <= 1'b1;
            end
`ifdef MICROWAVE_QUICK_START_EN
            else if (state_reg == IDLE && time_zero && door_closed) begin
              st_reg     <= QUICK_SECS_TENS;
              so_reg     <= 4'd0;
              state_reg  <= COOKING;
              mag_on_reg <= 1'b1;
            end
`endif
          end else if (key_valid && is_digit(key_digit)) begin
            mt_reg    <= mo_reg;
            mo_reg    <= st_reg;
            st_reg    <= so_reg;
            so_reg    <= key_digit;
            state_reg <= SETTING;
          end
        end

        COOKING: begin
          if (!door_closed || stop) begin
            state_reg  <= PAUSED;
            mag_on_reg <= 1'b0;
          end else if (tick_1hz) begin
            mt_reg <= dec_mt;
            mo_reg <= dec_mo;
            st_reg <= dec_st;
            so_reg <= dec_so;
            if (dec_zero) begin
              state_reg     <= DONE;
              mag_on_reg    <= 1'b0;
              done_reg      <= 1'b1;
              alarm_cnt_reg <= 4'd0;
            end
          end
        end

        PAUSED: begin
          if (stop) begin
            mt_reg    <= 4'd0;
            mo_reg    <= 4'd0;
            st_reg    <= 4'd0;
            so_reg    <= 4'd0;
            state_reg <= IDLE;
          end else if (start && door_closed) begin
            state_reg  <= COOKING;
            mag_on_reg <= 1'b1;
          end
        end

        DONE: begin
          if (stop || start) begin
            state_reg     <= IDLE;
            done_reg      <= 1'b0;
            alarm_cnt_reg <= 4'd0;
          end else if (tick_1hz) begin
            if (alarm_cnt_reg == LAST_TICK) begin
              state_reg     <= IDLE;
              done_reg      <= 1'b0;
              alarm_cnt_reg <= 4'd0;
            end else begin
              alarm_cnt_reg <= alarm_cnt_reg + 4'd1;
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          mag_on_reg <= 1'b0;
          done_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign mins_tens = mt_reg;
  assign mins_ones = mo_reg;
  assign secs_tens = st_reg;
  assign secs_ones = so_reg;
  assign mag_on    = mag_on_reg;
  assign done      = done_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios with literal
// expectations followed by random stimulus, all checked every cycle against
// a behavioural model (time as minute/second integers, state as a label).
module tb_microwave_ctrl;

  localparam int DT = 3;
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       tick_1hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] mins_tens, mins_ones, secs_tens, secs_ones;
  logic       mag_on, done;
  logic [2:0] state;

  microwave_ctrl #(.DONE_TICKS(DT)) dut (
    .clk(clk), .clear_n(clear_n), .key_valid(key_valid), .key_digit(key_digit),
    .tick_1hz(tick_1hz), .start(start), .stop(stop), .door_closed(door_closed),
    .mins_tens(mins_tens), .mins_ones(mins_ones), .secs_tens(secs_tens),
    .secs_ones(secs_ones), .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: four entered digits (0 = leftmost), a state label, alarm ticks seen.
  int m_dig[4];
  int m_state;
  int m_ticks;

  function automatic bit m_zero();
    return (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) == 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_state = S_IDLE;
    m_ticks = 0;
  endtask

  task automatic m_step();
    int mins, secs;
    if (!clear_n) begin
      m_reset();
      return;
    end
    case (m_state)
      S_IDLE, S_SET: begin
        if (stop) begin
          for (int i = 0; i < 4; i++) m_dig[i] = 0;
          m_state = S_IDLE;
        end else if (start) begin
          if (!m_zero() && door_closed) m_state = S_COOK;
`ifdef MICROWAVE_QUICK_START_EN
          else if (m_state == S_IDLE && m_zero() && door_closed) begin
            m_dig[2] = 3;
            m_state = S_COOK;
          end
`endif
        end else if (key_valid && key_digit < 10) begin
          for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i+1];
          m_dig[3] = int'(key_digit);
          m_state = S_SET;
        end
      end
      S_COOK: begin
        if (!door_closed || stop) m_state = S_PAUSE;
        else if (tick_1hz) begin
          mins = m_dig[0] * 10 + m_dig[1];
          secs = m_dig[2] * 10 + m_dig[3];
          if (secs > 0) secs = secs - 1;
          else begin
            secs = 59;
            mins = mins - 1;
          end
          m_dig[0] = mins / 10; m_dig[1] = mins % 10;
          m_dig[2] = secs / 10; m_dig[3] = secs % 10;
          if (mins == 0 && secs == 0) begin
            m_state = S_DONE;
            m_ticks = 0;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          for (int i = 0; i < 4; i++) m_dig[i] = 0;
          m_state = S_IDLE;
        end else if (start && door_closed) m_state = S_COOK;
      end
      default: begin
        if (stop || start) m_state = S_IDLE;
        else if (tick_1hz) begin
          m_ticks++;
          if (m_ticks == DT) m_state = S_IDLE;
        end
      end
    endcase
  endtask

  task automatic compare_model(input string tag);
    logic [15:0] exp_t, got_t;
    bit exp_mag, exp_done;
    exp_t = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
    got_t = {mins_tens, mins_ones, secs_tens, secs_ones};
    exp_mag  = (m_state == S_COOK);
    exp_done = (m_state == S_DONE);
    n_vec++;
    if (got_t !== exp_t || mag_on !== exp_mag || done !== exp_done ||
        state !== 3'(m_state)) begin
      n_bad++;
      $display("FAIL %s t=%0t: got time=%h mag=%b done=%b state=%0d, required time=%h mag=%b done=%b state=%0d",
               tag, $time, got_t, mag_on, done, state, exp_t, exp_mag, exp_done, m_state);
    end
  endtask

  task automatic lit(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] t_now();
    return {mins_tens, mins_ones, secs_tens, secs_ones};
  endfunction

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    compare_model("model");
    @(negedge clk);
    key_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic key(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    cyc();
  endtask

  task automatic do_start(); start = 1'b1; cyc(); endtask
  task automatic do_stop();  stop = 1'b1;  cyc(); endtask
  task automatic do_tick();  tick_1hz = 1'b1; cyc(); cyc(); endtask

  initial begin
    m_reset();
    @(negedge clk);
    #1;
    lit("reset_time", 32'(t_now()), 32'h0000);
    lit("reset_state", 32'(state), 32'd0);
    lit("reset_flags", 32'({mag_on, done}), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    cyc();

    // Key entry, then an out-of-range code.
    key(1); key(2); key(3); key(0);
    lit("keys_1230", 32'(t_now()), 32'h1230);
    lit("keys_state", 32'(state), 32'd1);
    key(12);
    lit("key_12_ignored", 32'(t_now()), 32'h1230);
    key(4);
    lit("fifth_digit_drop", 32'(t_now()), 32'h2304);
    do_stop();

    // 00:03 cook to done, then alarm expiry.
    key(0); key(0); key(0); key(3);
    do_start();
    lit("cook_mag_on", 32'(mag_on), 32'd1);
    do_tick(); do_tick(); do_tick();
    lit("done_time", 32'(t_now()), 32'h0000);
    lit("done_flags", 32'({mag_on, done}), 32'b01);
    do_tick(); do_tick();
    lit("done_still", 32'(done), 32'd1);
    do_tick();
    lit("done_expired", 32'({done, state}), 32'(3'd0));

    // 01:00, one tick, door opens, resume.
    key(1); key(0); key(0);
    do_start();
    do_tick();
    lit("borrow_0059", 32'(t_now()), 32'h0059);
    door_closed = 1'b0;
    cyc();
    lit("door_pause", 32'({mag_on, state}), 32'({1'b0, 3'd3}));
    door_closed = 1'b1;
    do_start();
    lit("resume", 32'({mag_on, state, t_now()}), 32'({1'b1, 3'd2, 16'h0059}));
    do_stop();
    do_stop();
    lit("stop_clear", 32'({state, t_now()}), 32'({3'd0, 16'h0000}));

    // Start and key together: start wins.
    key(5);
    start = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    cyc();
    lit("start_beats_key", 32'({state, t_now()}), 32'({3'd2, 16'h0005}));
    do_stop();
    lit("stop_pause", 32'(state), 32'd3);
    do_stop();
    lit("stop_idle", 32'({state, t_now()}), 32'({3'd0, 16'h0000}));

    // Start with zero time.
    do_start();
`ifdef MICROWAVE_QUICK_START_EN
    lit("quick_start", 32'({state, t_now()}), 32'({3'd2, 16'h0030}));
`else
    lit("zero_start", 32'({state, t_now()}), 32'({3'd0, 16'h0000}));
`endif
    do_stop(); do_stop();

    // Asynchronous clear mid-cook at 02:17.
    key(2); key(1); key(7);
    do_start();
    #2;
    clear_n = 1'b0;
    #1;
    lit("async_clear", 32'({state, mag_on, done, t_now()}), 32'd0);
    m_reset();
    @(negedge clk);
    cyc();
    clear_n = 1'b1;
    cyc();

    // Random phase.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) door_closed = ~door_closed;
      else if (!door_closed && $urandom_range(0, 99) < 20) door_closed = 1'b1;
      key_valid = ($urandom_range(0, 99) < 25);
      key_digit = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 99) < 6);
      stop      = ($urandom_range(0, 99) < 3);
      tick_1hz  = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 999) < 2) begin
        clear_n = 1'b0;
        cyc();
        clear_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
